// File: rtl/burst_mem_if.sv
// Request/response bundle for burst_mem; master drives requests, slave is the memory.
interface burst_mem_if #(
   parameter int log2_number_of_cells = 8,
   parameter int cell_size            = 8,
   parameter int max_access_cells     = 4
);
   localparam int SW = $clog2(max_access_cells);
   localparam int W  = max_access_cells * cell_size;

   logic                            start;
   logic                            we;
   logic                            re;
   logic [log2_number_of_cells-1:0] addr_bus;
   logic [SW-1:0]                   size;
   logic [W-1:0]                    data_bus_in;
   logic [W-1:0]                    data_bus_out;
   logic                            busy;
   logic                            done;
   logic                            err;
   logic                            parity_err;

   modport master (
      output start, we, re, addr_bus, size, data_bus_in,
      input  data_bus_out, busy, done, err, parity_err
   );

   modport slave (
      input  start, we, re, addr_bus, size, data_bus_in,
      output data_bus_out, busy, done, err, parity_err
   );
endinterface

// File: rtl/burst_mem.sv
// Burst memory moving 1..max_access_cells cells per request, one per clock; done n+1 edges after start.
// Starts while busy or in DONE are dropped silently; optional parity under BURST_MEM_PARITY_EN.
module burst_mem #(
   parameter int log2_number_of_cells = 8,
   parameter int cell_size            = 8,
   parameter int max_access_cells     = 4
) (
   input logic        clk,
   input logic        rst,
   burst_mem_if.slave bus
);
   localparam int SW    = $clog2(max_access_cells);
   localparam int W     = max_access_cells * cell_size;
   localparam int DEPTH = 2 ** log2_number_of_cells;

   typedef logic [log2_number_of_cells-1:0] addr_t;
   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t               state_q;
   logic [cell_size-1:0] mem [DEPTH];
   addr_t                addr_q;
   logic [SW-1:0]        size_q;
   logic [SW-1:0]        cnt_q;
   logic [SW-1:0]        cnt_d;
   logic [W-1:0]         wdata_q;
   logic [W-1:0]         rdata_q;
   logic [W-1:0]         rdata_d;
   logic                 wr_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 err_q;
   addr_t                cell_addr;
   logic [cell_size-1:0] wlane;
   logic [cell_size-1:0] rcell;

   assign cell_addr = addr_q + addr_t'(cnt_q);
   assign cnt_d     = cnt_q + 1'b1;
   assign wlane     = wdata_q[int'(cnt_q)*cell_size +: cell_size];
   assign rcell     = mem[cell_addr];

   // First read beat also zeroes lanes beyond this request's cell count.
   always_comb begin
      rdata_d = rdata_q;
      if (cnt_q == '0) begin
         for (int k = 1; k < max_access_cells; k++) begin
            if (k > int'(size_q)) rdata_d[k*cell_size +: cell_size] = '0;
         end
      end
      rdata_d[int'(cnt_q)*cell_size +: cell_size] = rcell;
   end

`ifdef BURST_MEM_PARITY_EN
   logic par_mem [DEPTH];
   logic parity_err_q;
   assign bus.parity_err = parity_err_q;
`else
   assign bus.parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         size_q  <= '0;
         cnt_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wr_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef BURST_MEM_PARITY_EN
         parity_err_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) par_mem[i] <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (bus.we ^ bus.re) begin
                     addr_q  <= bus.addr_bus;
                     size_q  <= bus.size;
                     wdata_q <= bus.data_bus_in;
                     wr_q    <= bus.we;
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     state_q <= XFER;
`ifdef BURST_MEM_PARITY_EN
                     parity_err_q <= 1'b0;
`endif
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            XFER: begin
               if (wr_q) begin
                  mem[cell_addr] <= wlane;
`ifdef BURST_MEM_PARITY_EN
                  par_mem[cell_addr] <= ^wlane;
`endif
               end else begin
                  rdata_q <= rdata_d;
`ifdef BURST_MEM_PARITY_EN
                  if ((^rcell) != par_mem[cell_addr]) parity_err_q <= 1'b1;
`endif
               end
               cnt_q <= cnt_d;
               if (cnt_q == size_q) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.data_bus_out = rdata_q;
   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;
endmodule

// File: tb/tb_burst_mem.sv
// Directed bench for burst_mem: hand-computed vectors through a single checking task.
module tb_burst_mem;
   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   burst_mem_if bus ();
   burst_mem dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one request, returns edges-to-done and busy after each edge (bit i = edge i+1).
   task automatic xfer(input logic w, input logic [7:0] a, input logic [1:0] sz,
                       input logic [31:0] d, output int lat, output logic [7:0] bmask);
      bus.start = 1'b1; bus.we = w; bus.re = !w;
      bus.addr_bus = a; bus.size = sz; bus.data_bus_in = d;
      bmask = '0;
      step();
      lat = 1;
      bmask[0] = bus.busy;
      bus.start = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
      while (!bus.done && lat < 12) begin
         step();
         bmask[lat] = bus.busy;
         lat++;
      end
      chk("done_seen", {63'd0, bus.done}, 64'd1);
      step();
   endtask

   int         lat;
   logic [7:0] bm;
   int         err_seen;

   initial begin
      n_chk = 0; n_err = 0;
      rst = 1'b1;
      bus.start = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
      bus.addr_bus = '0; bus.size = '0; bus.data_bus_in = '0;
      repeat (3) step();
      chk("rst_busy", {63'd0, bus.busy}, 64'd0);
      chk("rst_done", {63'd0, bus.done}, 64'd0);
      chk("rst_err", {63'd0, bus.err}, 64'd0);
      chk("rst_pe", {63'd0, bus.parity_err}, 64'd0);
      chk("rst_dout", {32'd0, bus.data_bus_out}, 64'd0);
      rst = 1'b0;

      xfer(1'b0, 8'h00, 2'd3, 32'h0, lat, bm);
      chk("rd4_lat", 64'(lat), 64'd5);
      chk("rd4_busy", {56'd0, bm}, 64'h0F);
      chk("rd4_zero", {32'd0, bus.data_bus_out}, 64'h0);

      xfer(1'b1, 8'h00, 2'd1, 32'h0000_3812, lat, bm);
      chk("wr2_lat", 64'(lat), 64'd3);
      chk("wr2_dout_hold", {32'd0, bus.data_bus_out}, 64'h0);
      xfer(1'b0, 8'h00, 2'd1, 32'h0, lat, bm);
      chk("rd2", {32'd0, bus.data_bus_out}, 64'h3812);
      xfer(1'b0, 8'h01, 2'd0, 32'h0, lat, bm);
      chk("rd1_mem1", {32'd0, bus.data_bus_out}, 64'h38);
      chk("rd1_lat", 64'(lat), 64'd2);

      xfer(1'b1, 8'h04, 2'd3, 32'h7894_5658, lat, bm);
      xfer(1'b0, 8'h04, 2'd3, 32'h0, lat, bm);
      chk("rd4_at4", {32'd0, bus.data_bus_out}, 64'h7894_5658);
      xfer(1'b0, 8'h06, 2'd0, 32'h0, lat, bm);
      chk("rd1_at6", {32'd0, bus.data_bus_out}, 64'h94);
      xfer(1'b1, 8'h20, 2'd0, 32'h55, lat, bm);
      chk("wr_hold", {32'd0, bus.data_bus_out}, 64'h94);

      xfer(1'b1, 8'hFE, 2'd3, 32'hAABB_CCDD, lat, bm);
      xfer(1'b0, 8'hFE, 2'd3, 32'h0, lat, bm);
      chk("wrap_rd4", {32'd0, bus.data_bus_out}, 64'hAABB_CCDD);
      xfer(1'b0, 8'h00, 2'd0, 32'h0, lat, bm);
      chk("wrap_m00", {32'd0, bus.data_bus_out}, 64'hBB);
      xfer(1'b0, 8'h01, 2'd0, 32'h0, lat, bm);
      chk("wrap_m01", {32'd0, bus.data_bus_out}, 64'hAA);
      xfer(1'b0, 8'hFF, 2'd0, 32'h0, lat, bm);
      chk("wrap_mFF", {32'd0, bus.data_bus_out}, 64'hCC);

      // Illegal starts: both and neither direction.
      bus.start = 1'b1; bus.we = 1'b1; bus.re = 1'b1;
      bus.addr_bus = 8'h04; bus.size = 2'd3; bus.data_bus_in = 32'hDEAD_BEEF;
      step();
      bus.start = 1'b0; bus.we = 1'b0; bus.re = 1'b0;
      chk("ill_err", {63'd0, bus.err}, 64'd1);
      chk("ill_busy", {63'd0, bus.busy}, 64'd0);
      chk("ill_dout", {32'd0, bus.data_bus_out}, 64'hCC);
      step();
      chk("ill_err_pulse", {63'd0, bus.err}, 64'd0);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("ill0_err", {63'd0, bus.err}, 64'd1);
      step();
      xfer(1'b0, 8'h04, 2'd3, 32'h0, lat, bm);
      chk("ill_mem", {32'd0, bus.data_bus_out}, 64'h7894_5658);

      // Conflicting start held throughout a 4-cell write must be dropped.
      bus.start = 1'b1; bus.we = 1'b1; bus.re = 1'b0;
      bus.addr_bus = 8'h40; bus.size = 2'd3; bus.data_bus_in = 32'h1122_3344;
      step();
      bus.addr_bus = 8'h40; bus.size = 2'd0; bus.data_bus_in = 32'hDEAD_BEEF;
      err_seen = 0;
      lat = 1;
      while (!bus.done && lat < 12) begin
         step();
         lat++;
         if (bus.err) err_seen++;
      end
      bus.start = 1'b0; bus.we = 1'b0;
      chk("busy_lat", 64'(lat), 64'd5);
      chk("busy_noerr", 64'(err_seen), 64'd0);
      step();
      xfer(1'b0, 8'h40, 2'd3, 32'h0, lat, bm);
      chk("busy_wr_intact", {32'd0, bus.data_bus_out}, 64'h1122_3344);

      // Reset sampled at T2 of a 4-cell write.
      bus.start = 1'b1; bus.we = 1'b1; bus.re = 1'b0;
      bus.addr_bus = 8'h10; bus.size = 2'd3; bus.data_bus_in = 32'hCAFE_F00D;
      step();
      bus.start = 1'b0; bus.we = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_busy", {63'd0, bus.busy}, 64'd0);
      chk("mid_done", {63'd0, bus.done}, 64'd0);
      chk("mid_dout", {32'd0, bus.data_bus_out}, 64'h0);
      xfer(1'b0, 8'h10, 2'd3, 32'h0, lat, bm);
      chk("mid_rd10", {32'd0, bus.data_bus_out}, 64'h0);
      xfer(1'b0, 8'h04, 2'd3, 32'h0, lat, bm);
      chk("mid_rd04", {32'd0, bus.data_bus_out}, 64'h0);

`ifdef BURST_MEM_PARITY_EN
      xfer(1'b1, 8'h04, 2'd3, 32'h7894_5658, lat, bm);
      xfer(1'b0, 8'h04, 2'd3, 32'h0, lat, bm);
      chk("par_clean", {63'd0, bus.parity_err}, 64'd0);
      dut.par_mem[4] = ~dut.par_mem[4];
      xfer(1'b0, 8'h04, 2'd3, 32'h0, lat, bm);
      chk("par_data", {32'd0, bus.data_bus_out}, 64'h7894_5658);
      chk("par_err", {63'd0, bus.parity_err}, 64'd1);
      step();
      chk("par_sticky", {63'd0, bus.parity_err}, 64'd1);
      xfer(1'b0, 8'h05, 2'd0, 32'h0, lat, bm);
      chk("par_clr", {63'd0, bus.parity_err}, 64'd0);
`else
      chk("par_tied", {63'd0, bus.parity_err}, 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/burst_mem.md
Name: burst_mem

Overview:
- Parametrised successor to generic_mem: a synchronous cell-addressed memory that moves 1..MAX_CELLS consecutive cells per request.
- Transfers are driven by a start/busy/done handshake, one cell per clock, packed little-endian.
- Replaces the bench-side loadn/readn tasks with hardware multi-cell access.
- Sits between the CPU load/store unit and the backing store.

Parameters:
- log2_number_of_cells, 8, address width; depth = 2**log2_number_of_cells cells.
- cell_size, 8, bits per cell.
- max_access_cells, 4, maximum cells per request; power of two, at least 2.
- SW (localparam), $clog2(max_access_cells), width of the size field.
- W (localparam), max_access_cells*cell_size, width of the data buses.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- we  in  1  write request; qualified by start.
- re  in  1  read request; qualified by start.
- addr_bus  in  log2_number_of_cells  first cell address.
- size  in  SW  cell count minus 1 (0 means 1 cell, max_access_cells-1 means max).
- data_bus_in  in  W  write data; lane k = bits [k*cell_size +: cell_size].
- data_bus_out  out  W  read data; lanes at or above the cell count are 0.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on an illegal request.
- parity_err  out  1  parity error flag (see Optional Feature).

Behaviour:
- Clock and reset: clk is the only clock. rst is synchronous and active-high. It wins over everything else.
- Reset effect: all cells are cleared to 0 and the FSM goes to IDLE. data_bus_out, busy, done, err and parity_err all go to 0.
- Reset mid-transfer: the transfer is aborted with no done pulse. All memory is zero after reset. A start is accepted on the first edge with rst low.
- FSM states: IDLE, XFER, DONE.
- IDLE: on an edge with start=1 and exactly one of we/re high, latch addr_bus, size, data_bus_in and the direction, load cnt=0, go to XFER, busy=1. Call this edge T0.
- Illegal request: start with we=re=1 or we=re=0 gives err=1 for one cycle and the FSM stays in IDLE. Memory and data_bus_out are unchanged.
- XFER: on edge T(k+1), k=0..n-1 with n=size+1, one cell is transferred.
- Write cell: mem[(addr+k) mod depth] <= latched lane k.
- Read cell: data_bus_out lane k <= mem[(addr+k) mod depth].
- Read clear: at T1 all data_bus_out lanes not being read in this request are cleared to 0.
- Transfer end: at edge Tn, busy goes to 0, done goes to 1 and the FSM moves to DONE.
- Latency: n+1 edges from start to done high, i.e. 2 for 1 cell and 5 for 4 cells.
- DONE: lasts one cycle, then the FSM returns to IDLE and done goes to 0. A start during DONE is ignored.
- Back-to-back: a new request is accepted two edges after Tn at the earliest.
- Busy handling: start is ignored while busy or in DONE, with no err. Inputs other than rst are don't-care after T0.
- Address wrap: modulo depth within a burst, e.g. 0xFF+1 -> 0x00.
- Read data hold: data_bus_out holds its last read value until the next read's T1. Writes never change it.
- Ordering: a read issued after a write's done returns the written data.

Optional Feature:
- Macro: BURST_MEM_PARITY_EN.
- When defined:
  - Each cell stores one extra even-parity bit, computed at write and cleared to 0 by reset.
  - Each read cell is checked at its XFER edge.
  - A mismatch sets parity_err, which is sticky until the next accepted start or rst. Data is still returned.
  - The parity array is named par_mem so a bench can corrupt it hierarchically.
- When undefined: no parity storage exists and parity_err is tied to 0.

Test Plan:
- Reset, then 4-cell read at 0x00 -> data_bus_out=0x00000000. done is high 5 edges after start and busy is high for edges 1..4.
- Write size=1 (2 cells) data 0x00003812 at 0x00, then 2-cell read at 0x00 -> mem[0]=0x12, mem[1]=0x38, data_bus_out=0x00003812.
- Write 4 cells 0x78945658 at 0x04, then 4-cell read -> 0x78945658. Then 1-cell read at 0x06 -> 0x00000094, with upper lanes 0.
- Wrap: write 4 cells 0xAABBCCDD at 0xFE -> mem[FE]=DD, mem[FF]=CC, mem[00]=BB, mem[01]=AA. A 4-cell read at 0xFE returns 0xAABBCCDD.
- Illegal and busy starts:
  - start with we=re=1 -> err pulses 1 cycle, busy stays 0 and memory is unchanged.
  - A second start during a 4-cell write -> ignored, and the first write completes intact.
- Reset mid-write plus parity (macro on):
  - rst at T2 of a 4-cell write at 0x10 -> busy=0 and done=0 next cycle, and a read at 0x10 returns 0.
  - Flip par_mem[0x04], then read at 0x04 -> parity_err=1 until the next start.
